io_channel_model: RTL
=====================

# io_channel_model

Parametrised, multi-channel successor to the single-channel parallel I/O device models in the CPU test bench. Each channel replays a preloaded list of {interval, data} entries. An input channel presents data and pulses a set request toward the CPU's FGI. An output channel samples CPU data on its set request, checks it against the expected value and counts mismatches. The block sits beside the CPU in the bench, driven by the same clock and SC-clear tick. Vectors are written through a load port rather than read from a file, so the block is synthesizable for on-board runs.

## Interface
- CH, 2, number of channels
- CHW, 1, width of channel select (≥ clog2(CH), min 1)
- DW, 8, data width per channel
- IW, 8, interval counter width
- DEPTH, 16, vector entries per channel
- AW, 4, entry address width (clog2(DEPTH))
- CW, 16, per-channel mismatch/transfer counter width
- MODE, {CH{1'b0}}, per-channel direction mask: bit c = 0 input device, 1 output checker

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- run  in  1  CPU in RUN state (com_ctl == COM_RUN); gates counting and firing
- tick  in  1  SC-clear pulse from CPU; one interval unit
- ld_we  in  1  vector write strobe
- ld_ch  in  CHW  channel to write
- ld_addr  in  AW  entry index
- ld_interval  in  IW  ticks before fire
- ld_data  in  DW  input data or expected output data
- ld_last  in  1  marks entry as final for that channel
- flg  in  CH  CPU flag per channel (FGI for input, FGO for output); 0 = device may act
- din  in  CH*DW  CPU OUTR per channel (output channels only; channel c at [c*DW +: DW])
- set  out  CH  one-cycle flag-set request to CPU
- dout  out  CH*DW  INPR per channel (input channels only)
- bsy  out  CH  1 unless channel is in WAIT with counter 0 (matches legacy fgi_bsy sense)
- done  out  CH  channel consumed its last entry
- xfer_cnt  out  CH*CW  completed transfers per channel
- err_cnt  out  CH*CW  output mismatches per channel (always 0 for input channels)

## Operation
- Storage per channel: DEPTH × {last, interval, data}, asynchronous read at ptr[c]. It is not cleared by rst. Writes are allowed at any time.
- Channel FSM states: IDLE, WAIT, ACK, DONE.
  - IDLE: if flg[c]==0 → WAIT, cnt ← interval[ptr].
  - WAIT: if run & tick & cnt≠0 → cnt−1. If run & flg[c]==0 & cnt==0 → fire: set[c] ← 1 for one cycle, ptr advances, xfer_cnt+1 (saturating), then:
    - → DONE if entry.last or ptr==DEPTH−1;
    - → ACK otherwise.
  - ACK: wait for flg[c]==1, then → IDLE. This blocks re-arming before the CPU flag rises.
  - DONE: terminal; done[c]=1; set never asserts again until rst.
- Fire, input channel: dout[c] ← data[ptr] on the fire edge; held until the next fire.
- Fire, output channel: compare din[c] with data[ptr] on the fire edge; on inequality, err_cnt+1 (saturating at all-ones).
- Fire and tick in the same cycle: fire wins; no decrement.
- run low: counter frozen, no fire; IDLE→WAIT arming and ACK→IDLE still proceed.
- Channels are fully independent; simultaneous fires on all channels are legal.
- Write to the entry currently armed: cnt already loaded and is not affected. The data used at fire is whatever is stored at that moment.
- Reset (any time, including mid-WAIT): all states IDLE, ptr=0, cnt=0, set=0, dout=0, xfer_cnt=0, err_cnt=0, done=0. bsy=1 follows from the state.

## Timing
- flg[c] low sampled in IDLE at edge N → WAIT after N.
- With interval 0: fire at edge N+1, so set[c]=1 during cycle N+2 only.
- With interval k: fire on the first edge after the k-th counted tick where flg==0 and run==1.
- dout and err_cnt update on the same edge that raises set.
- After fire, at least 1 cycle in ACK. Re-arm occurs no earlier than 1 cycle after flg is seen high then low again.
- All outputs are registered except bsy and done, which are decoded from state/cnt.

## Test plan
- Reset mid-WAIT: CH=2, ch0 loaded with interval 5, tick pulsed twice, rst asserted asynchronously → set=0, dout=0, ptr back to 0 immediately. After release, ch0 replays entry 0 from the start.
- Input, interval 0: ch0 input, entry0 {0, 0x41, last=0}, flg held 0 → set[0] pulses exactly one cycle, 2 cycles after the first flg-low sample, with dout[7:0]=0x41. The FSM stays in ACK until flg is driven 1.
- Interval countdown: interval 3, run=1, three ticks → fire on the edge after the 3rd tick. With run=0 during the ticks → no fire, cnt unchanged.
- Output check: ch1 output, expected {0xA5, 0x3C}, CPU drives din=0xA5 then 0x3D → err_cnt[1]=1, xfer_cnt[1]=2.
- Last and depth: entry 1 has last=1 → done=1 after the 2nd fire; no third set even with flg toggling. With no last bit set → DONE after entry DEPTH−1.
- Concurrency: both channels with interval 0, flg both low in the same cycle → both set bits pulse in the same cycle; the counters are independent.

Source files
------------

// File: rtl/io_channel_model.sv
// Multi-channel replay device: each channel steps through a preloaded list of
// {interval, data, last} entries, acting as an input source or an output checker.
module io_channel_model #(
   parameter int CH    = 2,
   parameter int CHW   = 1,
   parameter int DW    = 8,
   parameter int IW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int CW    = 16,
   parameter logic [CH-1:0] MODE = {CH{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              tick,
   input  logic              ld_we,
   input  logic [CHW-1:0]    ld_ch,
   input  logic [AW-1:0]     ld_addr,
   input  logic [IW-1:0]     ld_interval,
   input  logic [DW-1:0]     ld_data,
   input  logic              ld_last,
   input  logic [CH-1:0]     flg,
   input  logic [CH*DW-1:0]  din,
   output logic [CH-1:0]     set,
   output logic [CH*DW-1:0]  dout,
   output logic [CH-1:0]     bsy,
   output logic [CH-1:0]     done,
   output logic [CH*CW-1:0]  xfer_cnt,
   output logic [CH*CW-1:0]  err_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   logic [IW-1:0] mem_iv_q   [CH][DEPTH];
   logic [DW-1:0] mem_data_q [CH][DEPTH];
   logic          mem_last_q [CH][DEPTH];

   // Vector store survives reset so a bench can reload only what changes.
   always_ff @(posedge clk) begin
      if (ld_we && (int'(ld_ch) < CH)) begin
         mem_iv_q[ld_ch][ld_addr]   <= ld_interval;
         mem_data_q[ld_ch][ld_addr] <= ld_data;
         mem_last_q[ld_ch][ld_addr] <= ld_last;
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      state_t        state_q, state_d;
      logic [AW-1:0] ptr_q, ptr_d;
      logic [IW-1:0] cnt_q, cnt_d;
      logic          set_q, set_d;
      logic [DW-1:0] dout_q, dout_d;
      logic [CW-1:0] xfer_q, xfer_d;
      logic [CW-1:0] err_q, err_d;
      logic [DW-1:0] din_s;
      logic [DW-1:0] cur_data_s;
      logic [IW-1:0] cur_iv_s;
      logic          cur_last_s;
      logic          mismatch_s;

      assign din_s      = din[c*DW +: DW];
      assign cur_data_s = mem_data_q[c][ptr_q];
      assign cur_iv_s   = mem_iv_q[c][ptr_q];
      assign cur_last_s = mem_last_q[c][ptr_q];
      assign mismatch_s = MODE[c] && (din_s != cur_data_s);

      // Channel sequencing: arm, count ticks, fire, then wait for the CPU flag.
      always_comb begin
         state_d = state_q;
         ptr_d   = ptr_q;
         cnt_d   = cnt_q;
         set_d   = 1'b0;
         dout_d  = dout_q;
         xfer_d  = xfer_q;
         err_d   = err_q;
         case (state_q)
            S_IDLE: begin
               if (!flg[c]) begin
                  state_d = S_WAIT;
                  cnt_d   = cur_iv_s;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_WAIT: begin
               // Fire needs cnt==0 and a decrement needs cnt!=0, so fire always wins a tick.
               if (run && !flg[c] && (cnt_q == {IW{1'b0}})) begin
                  set_d  = 1'b1;
                  ptr_d  = ptr_q + AW'(1);
                  xfer_d = (xfer_q == {CW{1'b1}}) ? xfer_q : xfer_q + CW'(1);
                  if (MODE[c]) begin
                     err_d = (mismatch_s && (err_q != {CW{1'b1}})) ? err_q + CW'(1) : err_q;
                  end else begin
                     dout_d = cur_data_s;
                  end
                  state_d = (cur_last_s || (ptr_q == AW'(DEPTH - 1))) ? S_DONE : S_ACK;
               end else if (run && tick && (cnt_q != {IW{1'b0}})) begin
                  cnt_d = cnt_q - IW'(1);
               end else begin
                  cnt_d = cnt_q;
               end
            end
            S_ACK: begin
               if (flg[c]) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_ACK;
               end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
         endcase
      end

      // Channel state and registered outputs.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= {AW{1'b0}};
            cnt_q   <= {IW{1'b0}};
            set_q   <= 1'b0;
            dout_q  <= {DW{1'b0}};
            xfer_q  <= {CW{1'b0}};
            err_q   <= {CW{1'b0}};
         end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            dout_q  <= dout_d;
            xfer_q  <= xfer_d;
            err_q   <= err_d;
         end
      end

      assign set[c]               = set_q;
      assign dout[c*DW +: DW]     = dout_q;
      assign xfer_cnt[c*CW +: CW] = xfer_q;
      assign err_cnt[c*CW +: CW]  = err_q;
      assign bsy[c]               = !((state_q == S_WAIT) && (cnt_q == {IW{1'b0}}));
      assign done[c]              = (state_q == S_DONE);
   end

endmodule
